// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer.
// FSM state enum, drain length and default operand/length widths.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LEN_W    = 4;

endpackage

// File: rtl/mac_Nbits.sv
// Signed multiply-accumulate unit driven by mac_sequencer.
// Ports: clk, clr (sync active-high clear), en, w, x, acc (2*WIDTH wrap).
module mac_Nbits #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     w,
  input  logic signed [WIDTH-1:0]     x,
  output logic signed [2*WIDTH-1:0]   acc
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] prod;

  assign prod = PW'(w) * PW'(x);

  always_ff @(posedge clk) begin
    if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + prod;
  end

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams (w,x) pairs into an external MAC and
// captures the accumulated result behind a valid/ready handshake.
// Ports: clk, rst (sync, active-low), start/len, in_valid/in_ready,
// w_in/x_in, mac_clr/mac_en/mac_w/mac_x, mac_out, res_valid/res_ready,
// res_data, busy.
// Option: define MAC_SEQUENCER_RELU_EN to clamp negative results to 0.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   w_in,
  input  logic signed [WIDTH-1:0]   x_in,
  output logic                      mac_clr,
  output logic                      mac_en,
  output logic signed [WIDTH-1:0]   mac_w,
  output logic signed [WIDTH-1:0]   mac_x,
  input  logic signed [2*WIDTH-1:0] mac_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [2*WIDTH-1:0] res_data,
  output logic                      busy
);

  localparam logic [1:0] DLAST = 2'(DRAIN_CYCLES - 1);

  state_t st, nxt;

  logic [LEN_W-1:0]          cnt;
  logic [1:0]                dcnt;
  logic                      hs;
  logic                      go;
  logic                      last;
  logic signed [2*WIDTH-1:0] cap;

  assign in_ready  = (st == FEED);
  assign res_valid = (st == DONE);
  assign busy      = (st != IDLE);
  assign hs        = in_ready && in_valid;
  assign go        = (st == IDLE) && start;
  assign last      = (st == DRAIN) && (dcnt == DLAST);

`ifdef MAC_SEQUENCER_RELU_EN
  assign cap = mac_out[2*WIDTH-1] ? '0 : mac_out;
`else
  assign cap = mac_out;
`endif

  always_ff @(posedge clk) begin
    if (!rst)
      st <= IDLE;
    else
      st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:
        if (start)
          nxt = (len == '0) ? DONE : CLEAR;
      CLEAR:
        nxt = FEED;
      FEED:
        if (hs && cnt == LEN_W'(1))
          nxt = DRAIN;
      DRAIN:
        if (dcnt == DLAST)
          nxt = DONE;
      DONE:
        if (res_ready)
          nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  // mac_clr is registered from nxt so it is high exactly while in CLEAR;
  // the MAC therefore clears on the CLEAR->FEED edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      dcnt     <= '0;
      mac_en   <= 1'b0;
      mac_w    <= '0;
      mac_x    <= '0;
      mac_clr  <= 1'b1;
      res_data <= '0;
    end else begin
      mac_clr <= (nxt == CLEAR);
      mac_en  <= hs;
      dcnt    <= (st == DRAIN) ? dcnt + 2'd1 : 2'd0;
      if (hs) begin
        mac_w <= w_in;
        mac_x <= x_in;
        cnt   <= cnt - LEN_W'(1);
      end
      if (go) begin
        cnt <= len;
        if (len == '0)
          res_data <= '0;
      end
      if (last)
        res_data <= cap;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed self-checking bench for mac_sequencer with the mac_Nbits MAC.
// Expected results are hand-computed; ReLU clamp applied when enabled.
module tb_mac_sequencer;

  localparam int W = 8;
  localparam int L = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [L-1:0]            len;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     w_in;
  logic signed [W-1:0]     x_in;
  logic                    mac_clr;
  logic                    mac_en;
  logic signed [W-1:0]     mac_w;
  logic signed [W-1:0]     mac_x;
  logic signed [2*W-1:0]   mac_out;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [2*W-1:0]   res_data;
  logic                    busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_sequencer #(.WIDTH(W), .LEN_W(L)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .w_in(w_in), .x_in(x_in),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_w(mac_w), .mac_x(mac_x), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  mac_Nbits #(.WIDTH(W)) u_mac (
    .clk(clk), .clr(mac_clr), .en(mac_en),
    .w(mac_w), .x(mac_x), .acc(mac_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] expd(input int v);
    logic signed [15:0] r;
    r = 16'(v);
`ifdef MAC_SEQUENCER_RELU_EN
    if (r < 0)
      r = '0;
`endif
    return 32'(r);
  endfunction

  task automatic feed(input int a, input int b);
    in_valid = 1'b1;
    w_in     = 8'(a);
    x_in     = 8'(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic launch(input int n);
    len   = 4'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0;
    in_valid = 1'b0; w_in = '0; x_in = '0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mac_en", 32'(mac_en), 0);
    chk("rst_mac_w", 32'(mac_w), 0);
    chk("rst_mac_x", 32'(mac_x), 0);
    chk("rst_mac_clr", 32'(mac_clr), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    rst = 1'b1;
    tick();
    chk("rel_mac_clr", 32'(mac_clr), 0);
    chk("rel_busy", 32'(busy), 0);

    // dot product of length 2: -6 + -20
    res_ready = 1'b1;
    launch(2);
    chk("t1_clear_clr", 32'(mac_clr), 1);
    chk("t1_clear_busy", 32'(busy), 1);
    chk("t1_clear_rdy", 32'(in_ready), 0);
    tick();
    chk("t1_feed_rdy", 32'(in_ready), 1);
    chk("t1_feed_clr", 32'(mac_clr), 0);
    feed(-3, 2);
    chk("t1_mac_en", 32'(mac_en), 1);
    chk("t1_mac_w", 32'(mac_w), -3);
    chk("t1_mac_x", 32'(mac_x), 2);
    feed(5, -4);
    chk("t1_drain_rdy", 32'(in_ready), 0);
    chk("t1_lat0", 32'(res_valid), 0);
    tick();
    chk("t1_lat1", 32'(res_valid), 0);
    chk("t1_drain_en", 32'(mac_en), 0);
    tick();
    chk("t1_lat2", 32'(res_valid), 1);
    chk("t1_data", 32'(res_data), expd(-26));
    tick();
    chk("t1_idle_valid", 32'(res_valid), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // length 3 with a 4-cycle stall: -48 + 32 + 1
    launch(3);
    tick();
    feed(6, -8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_stall_en", 32'(mac_en), 0);
      chk("t2_stall_rdy", 32'(in_ready), 1);
    end
    feed(-8, -4);
    chk("t2_en2", 32'(mac_en), 1);
    feed(1, 1);
    tick();
    tick();
    chk("t2_valid", 32'(res_valid), 1);
    chk("t2_data", 32'(res_data), expd(-15));
    tick();

    // 16384 + 16384 wraps to -32768
    launch(2);
    tick();
    feed(-128, -128);
    feed(-128, -128);
    tick();
    tick();
    chk("t3_valid", 32'(res_valid), 1);
    chk("t3_data", 32'(res_data), expd(-32768));
    tick();

    // zero length goes straight to DONE and holds while stalled
    res_ready = 1'b0;
    launch(0);
    chk("t4_valid", 32'(res_valid), 1);
    chk("t4_data", 32'(res_data), 0);
    chk("t4_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      len   = 4'd3;
      start = (i % 2 == 0);
      tick();
      chk("t4_hold_valid", 32'(res_valid), 1);
      chk("t4_hold_data", 32'(res_data), 0);
      chk("t4_hold_rdy", 32'(in_ready), 0);
      chk("t4_hold_clr", 32'(mac_clr), 0);
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("t4_release", 32'(res_valid), 0);
    chk("t4_idle", 32'(busy), 0);

    // reset mid-FEED aborts, next run starts clean
    launch(3);
    tick();
    feed(7, 7);
    chk("t5_en", 32'(mac_en), 1);
    rst      = 1'b0;
    in_valid = 1'b1;
    w_in     = 8'sd1;
    x_in     = 8'sd1;
    tick();
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_valid", 32'(res_valid), 0);
    chk("t5_rst_clr", 32'(mac_clr), 1);
    chk("t5_rst_en", 32'(mac_en), 0);
    chk("t5_rst_rdy", 32'(in_ready), 0);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("t5_rel_busy", 32'(busy), 0);
    chk("t5_rel_clr", 32'(mac_clr), 0);
    chk("t5_rel_valid", 32'(res_valid), 0);
    launch(1);
    tick();
    feed(2, 3);
    tick();
    tick();
    chk("t5_valid", 32'(res_valid), 1);
    chk("t5_data", 32'(res_data), expd(6));
    tick();
    chk("t5_done", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
